execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage MIPS32 pipeline: ID/EX pipeline register, forwarding muxes, ALU, branch/jump target
//  generation and an iterative HI/LO multiply/divide unit. Feeds the Memory stage directly (all *_e outputs).
//  Raises md_stall while a MULT/DIV is in flight so the hazard unit freezes IF/ID/EX.
// PARAMETERS
//  MD_CYCLES   32   iterations of the mul/div datapath (one result bit per cycle)
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  stall_e        in   1   hold ID/EX register (from hazard unit)
//  flush_e        in   1   load bubble into ID/EX register
//  reg_write_d, mem_to_reg_d, mem_write_d, mem_access_d, branch_d  in 1 each  decode control bits
//  alu_ctrl_d     in   5   alu_op_t from exec_pkg
//  alu_src_d      in   1   1: operand B = sign_imm
//  reg_dst_d      in   2   00 rt, 01 rd, 10 r31
//  branch_type_d  in   4   0001 j, 0010 jal, 0011 jr, 0100 beq, 0101 bne, 0110 bgez, 0111 bltz
//  rd1_d, rd2_d   in   32  register file read data
//  rs_d, rt_d, rd_d in 5   register specifiers;  shamt_d in 5
//  sign_imm_d, pc_plus4_d, jump_addr_d  in 32
//  forward_a_e, forward_b_e  in 2   00 regfile, 01 result_w, 10 alu_out_m
//  alu_out_m, result_w       in 32  forwarding sources
//  reg_write_e, mem_to_reg_e, mem_write_e, mem_access_e, branch_e  out 1 each  registered controls
//  alu_out_e, write_data_e, pc_branch_e, jump_addr_e  out 32;  write_reg_e out 5;  branch_type_e out 4
//  zero_e         out  1   (src_a == src_b)
//  rs_e, rt_e     out  5   to hazard unit;  md_stall out 1
// BEHAVIOUR
//  - ID/EX reg: rst or flush_e -> all fields 0 (bubble); else stall_e or md_stall -> hold; else load *_d.
//    flush_e beats stall_e. All registered outputs reset to 0; HI=LO=0 on rst.
//  - src_a/src_b: forwarding mux per forward_*; write_data_e = forwarded B before alu_src mux; code 11 = regfile.
//  - ALU (combinational, 0 latency): ADD/SUB/ADDU/SUBU (wrap, no overflow trap), AND/OR/XOR/NOR, SLT (signed),
//    SLTU, SLL/SRL/SRA by shamt, SLLV/SRLV/SRAV by src_a[4:0], LUI {imm[15:0],16'b0}, PASS_A (bgez/bltz/jr),
//    LINK pc_plus4_e+4, MFHI/MFLO. Undefined op -> alu_out_e = 0.
//  - write_reg_e from reg_dst; pc_branch_e = pc_plus4_e + (sign_imm_e << 2), 32-bit wrap.
//  - Mul/div FSM states IDLE, BUSY, DONE; cnt 0..MD_CYCLES-1.
//    IDLE: is_md_e (MULT/MULTU/DIV/DIVU in EX) -> BUSY, capture operands/magnitudes, cnt=0.
//    BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; at cnt==MD_CYCLES-1 write HI/LO, -> DONE.
//    DONE: -> IDLE when !stall_e (stays in DONE under external stall, never restarts same instruction).
//    md_stall = is_md_e && state!=DONE  => MULT/DIV occupies EX for MD_CYCLES+2 cycles; HI/LO valid in DONE cycle.
//  - Signed ops: magnitudes, sign fix at end; DIV remainder takes dividend sign. Divide by zero:
//    LO=32'hFFFF_FFFF, HI=dividend, no trap. 0x80000000/-1 -> LO=0x80000000, HI=0.
//  - MTHI/MTLO write HI/LO at the edge leaving EX (not when stalled/flushed). MFHI after DONE reads new HI.
//  - flush_e or rst in BUSY/DONE -> IDLE, HI/LO unchanged (rst clears them), md_stall drops next cycle.
// STRUCTURE
//  - exec_pkg: alu_op_t enum, branch_type_t constants, reg_dst / forward select localparams, md_state_t.
//  - Sub-module mul_div_unit (FSM, HI/LO, iterative datapath); ALU, muxes and ID/EX register stay in execute_stage.
// TESTING
//  - ADD fwd: rd1=5, alu_out_m=7, forward_a=10, src_b=3 -> alu_out_e=10; SLT -8,3 -> 1; SLTU -8,3 -> 0.
//  - BEQ rd1=rd2=0x1234, pc_plus4=0x100, imm=4 -> zero_e=1, pc_branch_e=0x110; JAL -> alu_out_e=pc_plus4+4, write_reg_e=31.
//  - MULT 0xFFFF_FFFF*2 -> md_stall high 33 cycles, then HI=0xFFFF_FFFF LO=0xFFFF_FFFE; MFLO next -> 0xFFFF_FFFE.
//  - DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 9/0 -> LO=0xFFFF_FFFF, HI=9.
//  - flush_e at BUSY cnt=10 -> md_stall 0 next cycle, HI/LO unchanged, outputs are bubble (all controls 0).
//  - stall_e held 3 cycles in DONE -> no restart, HI/LO written once; rst mid-BUSY -> all outputs, HI, LO = 0.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared types for the EX stage.
//   alu_op_t      ALU / HI-LO operation encoding carried on alu_ctrl_*
//   branch_type_t branch/jump kind carried through EX to the branch unit
//   RD_* / FWD_*  register-destination and forwarding-mux select codes
//   md_state_t    mul/div sequencer states
//   idex_t        ID/EX pipeline register contents
package exec_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_ADDU   = 5'd2,
      ALU_SUBU   = 5'd3,
      ALU_AND    = 5'd4,
      ALU_OR     = 5'd5,
      ALU_XOR    = 5'd6,
      ALU_NOR    = 5'd7,
      ALU_SLT    = 5'd8,
      ALU_SLTU   = 5'd9,
      ALU_SLL    = 5'd10,
      ALU_SRL    = 5'd11,
      ALU_SRA    = 5'd12,
      ALU_SLLV   = 5'd13,
      ALU_SRLV   = 5'd14,
      ALU_SRAV   = 5'd15,
      ALU_LUI    = 5'd16,
      ALU_PASS_A = 5'd17,
      ALU_LINK   = 5'd18,
      ALU_MFHI   = 5'd19,
      ALU_MFLO   = 5'd20,
      ALU_MULT   = 5'd21,
      ALU_MULTU  = 5'd22,
      ALU_DIV    = 5'd23,
      ALU_DIVU   = 5'd24,
      ALU_MTHI   = 5'd25,
      ALU_MTLO   = 5'd26
   } alu_op_t;

   typedef enum logic [3:0] {
      BR_NONE = 4'b0000,
      BR_J    = 4'b0001,
      BR_JAL  = 4'b0010,
      BR_JR   = 4'b0011,
      BR_BEQ  = 4'b0100,
      BR_BNE  = 4'b0101,
      BR_BGEZ = 4'b0110,
      BR_BLTZ = 4'b0111
   } branch_type_t;

   localparam logic [1:0] RD_RT  = 2'b00;
   localparam logic [1:0] RD_RD  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_write;
      logic        mem_access;
      logic        branch;
      logic [4:0]  alu_ctrl;
      logic        alu_src;
      logic [1:0]  reg_dst;
      logic [3:0]  branch_type;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [31:0] sign_imm;
      logic [31:0] pc_plus4;
      logic [31:0] jump_addr;
   } idex_t;

   function automatic logic is_md_op(input logic [4:0] op);
      return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
   endfunction

endpackage

// File: rtl/execute_stage_mul_div.sv
// mul_div_unit: iterative HI/LO multiply/divide, one result bit per cycle.
//   clk, rst          clock, synchronous active-high reset (clears HI/LO)
//   stall_e, flush_e  EX hold / bubble from the hazard unit
//   alu_op            operation currently in EX
//   op_a, op_b        forwarded rs / rt values
//   hi, lo            architectural HI/LO
//   md_stall          high while a MULT/DIV in EX has not reached DONE
module mul_div_unit
   import exec_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_e,
   input  logic        flush_e,
   input  logic [4:0]  alu_op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        md_stall
);

   localparam int unsigned CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

   md_state_t   state;
   logic [CW-1:0] cnt;
   logic [63:0] acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
   logic [31:0] mag_b;
   logic [31:0] dividend;
   logic        is_div, neg_q, neg_r, div_zero;

   logic        is_md, is_signed;
   logic [31:0] mag_a_in, mag_b_in;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic [63:0] acc_next, prod;
   logic [31:0] res_hi, res_lo;

   assign is_md     = is_md_op(alu_op);
   assign is_signed = (alu_op == ALU_MULT) || (alu_op == ALU_DIV);
   assign mag_a_in  = (is_signed && op_a[31]) ? -op_a : op_a;
   assign mag_b_in  = (is_signed && op_b[31]) ? -op_b : op_b;
   assign md_stall  = is_md && (state != MD_DONE);

   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
      div_shift = {acc[63:32], acc[31]};
      div_diff  = div_shift - {1'b0, mag_b};
      if (is_div)
         acc_next = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};
      else
         acc_next = {mul_sum, acc[31:1]};

      prod   = neg_q ? -acc_next : acc_next;
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      if (is_div) begin
         if (div_zero) begin
            res_lo = '1;
            res_hi = dividend;
         end else begin
            res_lo = neg_q ? -acc_next[31:0] : acc_next[31:0];
            res_hi = neg_r ? -acc_next[63:32] : acc_next[63:32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= MD_IDLE;
         cnt      <= '0;
         acc      <= '0;
         mag_b    <= '0;
         dividend <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else if (flush_e) begin
         state <= MD_IDLE;
      end else begin
         case (state)
            MD_IDLE: begin
               if (is_md) begin
                  state    <= MD_BUSY;
                  cnt      <= '0;
                  acc      <= {32'd0, mag_a_in};
                  mag_b    <= mag_b_in;
                  dividend <= op_a;
                  is_div   <= (alu_op == ALU_DIV) || (alu_op == ALU_DIVU);
                  neg_q    <= is_signed && (op_a[31] ^ op_b[31]);
                  neg_r    <= is_signed && op_a[31];
                  div_zero <= (op_b == '0);
               end else if (!stall_e) begin
                  // MTHI/MTLO commit only on the edge the instruction leaves EX
                  if (alu_op == ALU_MTHI) hi <= op_a;
                  if (alu_op == ALU_MTLO) lo <= op_a;
               end
            end
            MD_BUSY: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  state <= MD_DONE;
               end
            end
            MD_DONE: begin
               if (!stall_e) state <= MD_IDLE;
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS32 EX stage -- ID/EX register, forwarding muxes, ALU,
// branch target, destination register select and HI/LO mul/div unit.
//   inputs  *_d            decode-stage fields latched into ID/EX
//           stall_e/flush_e hazard-unit hold / bubble
//           forward_*_e, alu_out_m, result_w  forwarding controls and sources
//   outputs *_e            EX results and registered controls for MEM
//           rs_e, rt_e     specifiers for the hazard unit; md_stall
module execute_stage
   import exec_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_e,
   input  logic        flush_e,
   input  logic        reg_write_d,
   input  logic        mem_to_reg_d,
   input  logic        mem_write_d,
   input  logic        mem_access_d,
   input  logic        branch_d,
   input  logic [4:0]  alu_ctrl_d,
   input  logic        alu_src_d,
   input  logic [1:0]  reg_dst_d,
   input  logic [3:0]  branch_type_d,
   input  logic [31:0] rd1_d,
   input  logic [31:0] rd2_d,
   input  logic [4:0]  rs_d,
   input  logic [4:0]  rt_d,
   input  logic [4:0]  rd_d,
   input  logic [4:0]  shamt_d,
   input  logic [31:0] sign_imm_d,
   input  logic [31:0] pc_plus4_d,
   input  logic [31:0] jump_addr_d,
   input  logic [1:0]  forward_a_e,
   input  logic [1:0]  forward_b_e,
   input  logic [31:0] alu_out_m,
   input  logic [31:0] result_w,
   output logic        reg_write_e,
   output logic        mem_to_reg_e,
   output logic        mem_write_e,
   output logic        mem_access_e,
   output logic        branch_e,
   output logic [31:0] alu_out_e,
   output logic [31:0] write_data_e,
   output logic [31:0] pc_branch_e,
   output logic [31:0] jump_addr_e,
   output logic [4:0]  write_reg_e,
   output logic [3:0]  branch_type_e,
   output logic        zero_e,
   output logic [4:0]  rs_e,
   output logic [4:0]  rt_e,
   output logic        md_stall
);

   idex_t       idex, idex_d;
   logic [31:0] src_a, src_b, hi, lo;

   always_comb begin
      idex_d             = '0;
      idex_d.reg_write   = reg_write_d;
      idex_d.mem_to_reg  = mem_to_reg_d;
      idex_d.mem_write   = mem_write_d;
      idex_d.mem_access  = mem_access_d;
      idex_d.branch      = branch_d;
      idex_d.alu_ctrl    = alu_ctrl_d;
      idex_d.alu_src     = alu_src_d;
      idex_d.reg_dst     = reg_dst_d;
      idex_d.branch_type = branch_type_d;
      idex_d.rd1         = rd1_d;
      idex_d.rd2         = rd2_d;
      idex_d.rs          = rs_d;
      idex_d.rt          = rt_d;
      idex_d.rd          = rd_d;
      idex_d.shamt       = shamt_d;
      idex_d.sign_imm    = sign_imm_d;
      idex_d.pc_plus4    = pc_plus4_d;
      idex_d.jump_addr   = jump_addr_d;
   end

   // flush beats any hold, including the internal mul/div stall
   always_ff @(posedge clk) begin
      if (rst || flush_e)
         idex <= '0;
      else if (!(stall_e || md_stall))
         idex <= idex_d;
   end

   always_comb begin
      case (forward_a_e)
         FWD_RF:  src_a = idex.rd1;
         FWD_W:   src_a = result_w;
         FWD_M:   src_a = alu_out_m;
         default: src_a = idex.rd1;
      endcase
      case (forward_b_e)
         FWD_RF:  write_data_e = idex.rd2;
         FWD_W:   write_data_e = result_w;
         FWD_M:   write_data_e = alu_out_m;
         default: write_data_e = idex.rd2;
      endcase
      src_b = idex.alu_src ? idex.sign_imm : write_data_e;
   end

   always_comb begin
      case (idex.alu_ctrl)
         ALU_ADD, ALU_ADDU: alu_out_e = src_a + src_b;
         ALU_SUB, ALU_SUBU: alu_out_e = src_a - src_b;
         ALU_AND:    alu_out_e = src_a & src_b;
         ALU_OR:     alu_out_e = src_a | src_b;
         ALU_XOR:    alu_out_e = src_a ^ src_b;
         ALU_NOR:    alu_out_e = ~(src_a | src_b);
         ALU_SLT:    alu_out_e = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
         ALU_SLTU:   alu_out_e = (src_a < src_b) ? 32'd1 : 32'd0;
         ALU_SLL:    alu_out_e = src_b << idex.shamt;
         ALU_SRL:    alu_out_e = src_b >> idex.shamt;
         ALU_SRA:    alu_out_e = $unsigned($signed(src_b) >>> idex.shamt);
         ALU_SLLV:   alu_out_e = src_b << src_a[4:0];
         ALU_SRLV:   alu_out_e = src_b >> src_a[4:0];
         ALU_SRAV:   alu_out_e = $unsigned($signed(src_b) >>> src_a[4:0]);
         ALU_LUI:    alu_out_e = {idex.sign_imm[15:0], 16'd0};
         ALU_PASS_A: alu_out_e = src_a;
         ALU_LINK:   alu_out_e = idex.pc_plus4 + 32'd4;
         ALU_MFHI:   alu_out_e = hi;
         ALU_MFLO:   alu_out_e = lo;
         default:    alu_out_e = '0;
      endcase
   end

   always_comb begin
      case (idex.reg_dst)
         RD_RT:   write_reg_e = idex.rt;
         RD_RD:   write_reg_e = idex.rd;
         RD_R31:  write_reg_e = 5'd31;
         default: write_reg_e = idex.rt;
      endcase
   end

   assign zero_e        = (src_a == src_b);
   assign pc_branch_e   = idex.pc_plus4 + {idex.sign_imm[29:0], 2'b00};
   assign jump_addr_e   = idex.jump_addr;
   assign branch_type_e = idex.branch_type;
   assign reg_write_e   = idex.reg_write;
   assign mem_to_reg_e  = idex.mem_to_reg;
   assign mem_write_e   = idex.mem_write;
   assign mem_access_e  = idex.mem_access;
   assign branch_e      = idex.branch;
   assign rs_e          = idex.rs;
   assign rt_e          = idex.rt;

   mul_div_unit #(.MD_CYCLES(MD_CYCLES)) u_md (
      .clk      (clk),
      .rst      (rst),
      .stall_e  (stall_e),
      .flush_e  (flush_e),
      .alu_op   (idex.alu_ctrl),
      .op_a     (src_a),
      .op_b     (write_data_e),
      .hi       (hi),
      .lo       (lo),
      .md_stall (md_stall)
   );

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed-vector bench for execute_stage.
module tb_execute_stage;
   import exec_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall_e, flush_e;
   logic        reg_write_d, mem_to_reg_d, mem_write_d, mem_access_d, branch_d;
   logic [4:0]  alu_ctrl_d;
   logic        alu_src_d;
   logic [1:0]  reg_dst_d;
   logic [3:0]  branch_type_d;
   logic [31:0] rd1_d, rd2_d, sign_imm_d, pc_plus4_d, jump_addr_d;
   logic [4:0]  rs_d, rt_d, rd_d, shamt_d;
   logic [1:0]  forward_a_e, forward_b_e;
   logic [31:0] alu_out_m, result_w;
   logic        reg_write_e, mem_to_reg_e, mem_write_e, mem_access_e, branch_e;
   logic [31:0] alu_out_e, write_data_e, pc_branch_e, jump_addr_e;
   logic [4:0]  write_reg_e, rs_e, rt_e;
   logic [3:0]  branch_type_e;
   logic        zero_e, md_stall;

   int vectors = 0;
   int miscompares = 0;
   int n;

   execute_stage #(.MD_CYCLES(32)) dut (
      .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
      .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
      .mem_access_d(mem_access_d), .branch_d(branch_d), .alu_ctrl_d(alu_ctrl_d),
      .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d), .branch_type_d(branch_type_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .shamt_d(shamt_d),
      .sign_imm_d(sign_imm_d), .pc_plus4_d(pc_plus4_d), .jump_addr_d(jump_addr_d),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .alu_out_m(alu_out_m), .result_w(result_w),
      .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
      .mem_access_e(mem_access_e), .branch_e(branch_e), .alu_out_e(alu_out_e),
      .write_data_e(write_data_e), .pc_branch_e(pc_branch_e), .jump_addr_e(jump_addr_e),
      .write_reg_e(write_reg_e), .branch_type_e(branch_type_e), .zero_e(zero_e),
      .rs_e(rs_e), .rt_e(rt_e), .md_stall(md_stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0; mem_access_d = 0; branch_d = 0;
      alu_src_d = 0; reg_dst_d = 0; branch_type_d = 0;
      rs_d = 0; rt_d = 0; rd_d = 0; shamt_d = 0;
      sign_imm_d = 0; pc_plus4_d = 0; jump_addr_d = 0;
      alu_ctrl_d = op; rd1_d = a; rd2_d = b;
   endtask

   // Counts cycles with md_stall high; bounded so a stuck unit still ends the run.
   task automatic wait_md(output int cycles);
      cycles = 0;
      while (md_stall && cycles < 100) begin
         cycles++;
         tick();
      end
   endtask

   task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int c;
      set_op(op, a, b);
      tick();
      set_op(ALU_MFLO, 0, 0);
      wait_md(c);
      check({tag, "_stall_cycles"}, c, 33);
      tick();
      check({tag, "_lo"}, alu_out_e, exp_lo);
      set_op(ALU_MFHI, 0, 0);
      tick();
      check({tag, "_hi"}, alu_out_e, exp_hi);
   endtask

   initial begin
      rst = 1; stall_e = 0; flush_e = 0;
      forward_a_e = 0; forward_b_e = 0; alu_out_m = 0; result_w = 0;
      set_op(ALU_ADD, 0, 0);
      tick(); tick();
      rst = 0;
      check("rst_ctrl", {reg_write_e, mem_to_reg_e, mem_write_e, mem_access_e, branch_e}, 0);
      check("rst_alu", alu_out_e, 0);
      check("rst_md_stall", md_stall, 0);

      // ADD with forwarded A
      set_op(ALU_ADD, 5, 3); reg_write_d = 1; reg_dst_d = RD_RD; rd_d = 8;
      tick();
      forward_a_e = FWD_M; alu_out_m = 7;
      #1;
      check("add_fwd", alu_out_e, 10);
      check("add_wreg", write_reg_e, 8);
      check("add_wdata", write_data_e, 3);
      check("add_regwrite", reg_write_e, 1);
      forward_a_e = FWD_RF; alu_out_m = 0;

      set_op(ALU_SLT, 32'hFFFF_FFF8, 3);  tick(); check("slt", alu_out_e, 1);
      set_op(ALU_SLTU, 32'hFFFF_FFF8, 3); tick(); check("sltu", alu_out_e, 0);
      set_op(ALU_SRA, 0, 32'h8000_0000); shamt_d = 4; tick(); check("sra", alu_out_e, 32'hF800_0000);
      set_op(ALU_SRLV, 4, 32'h80);        tick(); check("srlv", alu_out_e, 32'h8);
      set_op(ALU_LUI, 0, 0); alu_src_d = 1; sign_imm_d = 32'h1234; tick();
      check("lui", alu_out_e, 32'h1234_0000);
      set_op(5'd31, 9, 9); tick(); check("undef_op", alu_out_e, 0);

      // BEQ
      set_op(ALU_SUB, 32'h1234, 32'h1234); branch_d = 1; branch_type_d = BR_BEQ;
      pc_plus4_d = 32'h100; sign_imm_d = 4;
      tick();
      check("beq_zero", zero_e, 1);
      check("beq_target", pc_branch_e, 32'h110);
      check("beq_type", branch_type_e, 4'b0100);
      check("beq_branch", branch_e, 1);

      // JAL
      set_op(ALU_LINK, 0, 0); reg_write_d = 1; reg_dst_d = RD_R31; branch_type_d = BR_JAL;
      pc_plus4_d = 32'h200; jump_addr_d = 32'h0040_0000;
      tick();
      check("jal_link", alu_out_e, 32'h204);
      check("jal_wreg", write_reg_e, 31);
      check("jal_jaddr", jump_addr_e, 32'h0040_0000);

      // Mul/div results
      run_md("mult", ALU_MULT, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_md("div", ALU_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
      run_md("divu0", ALU_DIVU, 9, 0, 9, 32'hFFFF_FFFF);

      // Flush mid-BUSY: HI=9, LO=FFFFFFFF must survive
      set_op(ALU_MULTU, 3, 3);
      tick();
      repeat (11) tick();
      check("flush_pre_stall", md_stall, 1);
      flush_e = 1;
      set_op(ALU_MFHI, 0, 0); reg_write_d = 1; mem_write_d = 1; branch_d = 1;
      tick();
      flush_e = 0;
      check("flush_md_stall", md_stall, 0);
      check("flush_bubble", {reg_write_e, mem_to_reg_e, mem_write_e, mem_access_e, branch_e}, 0);
      tick();
      check("flush_hi", alu_out_e, 9);
      set_op(ALU_MFLO, 0, 0); tick();
      check("flush_lo", alu_out_e, 32'hFFFF_FFFF);

      // External stall held in DONE
      set_op(ALU_MULTU, 6, 7);
      tick();
      set_op(ALU_MFLO, 0, 0);
      wait_md(n);
      check("stall_done_cycles", n, 33);
      stall_e = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_done_no_restart", md_stall, 0);
      end
      stall_e = 0;
      tick();
      check("stall_done_lo", alu_out_e, 42);

      // MTHI commits on leaving EX
      set_op(ALU_MTHI, 32'hABCD_1234, 0); tick();
      set_op(ALU_MFHI, 0, 0); tick();
      check("mthi", alu_out_e, 32'hABCD_1234);

      // Reset mid-BUSY
      set_op(ALU_MULT, 5, 5);
      tick();
      repeat (5) tick();
      rst = 1;
      set_op(ALU_MFHI, 0, 0); reg_write_d = 1;
      tick();
      rst = 0;
      check("rstb_md_stall", md_stall, 0);
      check("rstb_ctrl", {reg_write_e, mem_to_reg_e, mem_write_e, mem_access_e, branch_e}, 0);
      check("rstb_alu", alu_out_e, 0);
      check("rstb_pcbr", pc_branch_e, 0);
      tick();
      check("rstb_hi", alu_out_e, 0);
      set_op(ALU_MFLO, 0, 0); tick();
      check("rstb_lo", alu_out_e, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
